valve_frame_serializer: RTL and testbench



---
 rtl/valve_frame_serializer_if.sv | 21 ++
 rtl/valve_frame_serializer.sv | 150 +++++++++++++++
 tb/tb_valve_frame_serializer.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/valve_frame_serializer_if.sv
// Valid/ready frame handshake between the ejection scheduler
// and the valveboard serializer.
interface valve_frame_serializer_if #(
    parameter int CHANNEL_NUM = 48
);
    logic [CHANNEL_NUM-1:0] frame_data;
    logic                   frame_valid;
    logic                   frame_ready;

    modport master (
        output frame_data,
        output frame_valid,
        input  frame_ready
    );

    modport slave (
        input  frame_data,
        input  frame_valid,
        output frame_ready
    );
endinterface

// File: rtl/valve_frame_serializer.sv
// Serializes 48-channel valve words onto the sen/sclk/sdata cable,
// LSB first, with periodic keepalive retransmission of the last word.
module valve_frame_serializer #(
    parameter int CHANNEL_NUM      = 48,
    parameter int SCLK_HALF_PERIOD = 10,
    parameter int SEN_SETUP        = 10,
    parameter int SEN_GAP          = 10,
    parameter int KEEPALIVE_PERIOD = 2_000_000
) (
    input  logic                           sys_clk,
    input  logic                           rst_n,
    valve_frame_serializer_if.slave        frame,
    input  logic                           abort,
    output logic                           line_sclk,
    output logic                           line_sen,
    output logic                           line_sdata,
    output logic                           frame_done,
    output logic                           keepalive_active
);
    localparam int PMAX0 = (SEN_SETUP > SEN_GAP) ? SEN_SETUP : SEN_GAP;
    localparam int PMAX  = (PMAX0 > SCLK_HALF_PERIOD) ? PMAX0 : SCLK_HALF_PERIOD;
    localparam int PW    = $clog2(PMAX + 1);
    localparam int KW    = $clog2(CHANNEL_NUM);
    localparam int AW    = $clog2(KEEPALIVE_PERIOD);

    localparam logic [PW-1:0] SETUP_LAST = PW'(SEN_SETUP - 1);
    localparam logic [PW-1:0] HALF_LAST  = PW'(SCLK_HALF_PERIOD - 1);
    localparam logic [PW-1:0] GAP_LAST   = PW'(SEN_GAP - 1);
    localparam logic [KW-1:0] K_LAST     = KW'(CHANNEL_NUM - 1);
    localparam logic [AW-1:0] KA_LAST    = AW'(KEEPALIVE_PERIOD - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_HI,
        SHIFT_LO,
        GAP
    } state_t;

    state_t                 state;
    logic [PW-1:0]          phase;
    logic [KW-1:0]          bit_idx;
    logic [CHANNEL_NUM-1:0] shift_reg;
    logic [CHANNEL_NUM-1:0] last_frame;
    logic [AW-1:0]          ka_cnt;
    logic                   busy;

    assign frame.frame_ready = (state == IDLE);
    assign busy = (state == SETUP) || (state == SHIFT_HI) ||
                  (state == SHIFT_LO);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            phase            <= '0;
            bit_idx          <= '0;
            shift_reg        <= '1;
            last_frame       <= '1;
            ka_cnt           <= '0;
            line_sclk        <= 1'b0;
            line_sen         <= 1'b0;
            line_sdata       <= 1'b1;
            frame_done       <= 1'b0;
            keepalive_active <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (ka_cnt != KA_LAST) ka_cnt <= ka_cnt + AW'(1);
            // abort drops the line at once; receiver discards the short frame
            if (abort && busy) begin
                state      <= GAP;
                phase      <= '0;
                line_sen   <= 1'b0;
                line_sclk  <= 1'b0;
                line_sdata <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (frame.frame_valid || ka_cnt == KA_LAST) begin
                            state     <= SETUP;
                            phase     <= '0;
                            ka_cnt    <= '0;
                            line_sen  <= 1'b1;
                            line_sclk <= 1'b0;
                            if (frame.frame_valid) begin
                                shift_reg  <= frame.frame_data;
                                last_frame <= frame.frame_data;
                                line_sdata <= frame.frame_data[0];
                            end else begin
                                shift_reg        <= last_frame;
                                line_sdata       <= last_frame[0];
                                keepalive_active <= 1'b1;
                            end
                        end
                    end
                    SETUP: begin
                        if (phase == SETUP_LAST) begin
                            state     <= SHIFT_HI;
                            phase     <= '0;
                            bit_idx   <= '0;
                            line_sclk <= 1'b1;
                        end else begin
                            phase <= phase + PW'(1);
                        end
                    end
                    SHIFT_HI: begin
                        if (phase == HALF_LAST) begin
                            state     <= SHIFT_LO;
                            phase     <= '0;
                            line_sclk <= 1'b0;
                            // next bit goes out on the falling edge
                            if (bit_idx != K_LAST) begin
                                line_sdata <= shift_reg[1];
                                shift_reg  <= shift_reg >> 1;
                            end
                        end else begin
                            phase <= phase + PW'(1);
                        end
                    end
                    SHIFT_LO: begin
                        if (phase == HALF_LAST) begin
                            phase <= '0;
                            if (bit_idx == K_LAST) begin
                                state      <= GAP;
                                line_sen   <= 1'b0;
                                line_sdata <= 1'b1;
                                frame_done <= 1'b1;
                            end else begin
                                state     <= SHIFT_HI;
                                bit_idx   <= bit_idx + KW'(1);
                                line_sclk <= 1'b1;
                            end
                        end else begin
                            phase <= phase + PW'(1);
                        end
                    end
                    GAP: begin
                        if (phase == GAP_LAST) begin
                            state            <= IDLE;
                            phase            <= '0;
                            keepalive_active <= 1'b0;
                        end else begin
                            phase <= phase + PW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_valve_frame_serializer.sv
// Bench for valve_frame_serializer: cable-side receiver model,
// vector table, random frames, keepalive, abort and reset sequences.
module tb_valve_frame_serializer;
    localparam int N    = 48;
    localparam int HALF = 10;
    localparam int SETP = 10;
    localparam int GAPC = 10;
    localparam int KP   = 5000;
    localparam int SENL = SETP + 2 * HALF * N;
    localparam int RLAT = SENL + GAPC;

    logic sys_clk = 1'b0;
    logic rst_n;
    logic abort;
    logic sclk, sen, sdata, done, ka;

    valve_frame_serializer_if #(.CHANNEL_NUM(N)) bus ();

    valve_frame_serializer #(
        .CHANNEL_NUM(N),
        .SCLK_HALF_PERIOD(HALF),
        .SEN_SETUP(SETP),
        .SEN_GAP(GAPC),
        .KEEPALIVE_PERIOD(KP)
    ) dut (
        .sys_clk(sys_clk),
        .rst_n(rst_n),
        .frame(bus.slave),
        .abort(abort),
        .line_sclk(sclk),
        .line_sen(sen),
        .line_sdata(sdata),
        .frame_done(done),
        .keepalive_active(ka)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [N-1:0] word;
        logic         ka;
        int           rise;
        int           len;
    } rx_t;

    typedef struct {
        logic [N-1:0] data;
        int           exp_len;
        int           exp_lat;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // receiver model state
    rx_t          rxq[$];
    int           abq[$];
    logic [N-1:0] word;
    logic         ka_r;
    logic         p_sen = 1'b0;
    logic         p_sclk = 1'b0;
    int nbits = 0, rise_cyc = 0, fall_cyc = 0, last_gap = -1;
    int last_edge = 0, viol = 0, spacing_err = 0;
    int done_cnt = 0, n_full = 0;
    bit seen_fall = 1'b0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        rx_t r;
        if (sen && !p_sen) begin
            if (seen_fall) last_gap = cyc - fall_cyc;
            rise_cyc = cyc;
            nbits = 0;
            word = '0;
            ka_r = ka;
        end
        if (sclk && !p_sclk) begin
            if (!sen) viol++;
            else begin
                if (nbits > 0 && cyc - last_edge != 2 * HALF)
                    spacing_err++;
                if (nbits < N) word[nbits] = sdata;
                last_edge = cyc;
                nbits++;
            end
        end
        if (!sen && p_sen) begin
            fall_cyc = cyc;
            seen_fall = 1'b1;
            if (nbits == N) begin
                r.word = word;
                r.ka = ka_r;
                r.rise = rise_cyc;
                r.len = cyc - rise_cyc;
                rxq.push_back(r);
                n_full++;
            end else begin
                abq.push_back(nbits);
            end
        end
        if (done) done_cnt++;
        p_sen = sen;
        p_sclk = sclk;
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge sys_clk);
        #1;
    endtask

    task automatic send(input logic [N-1:0] d, output int acc);
        int n = 0;
        step();
        bus.frame_data = d;
        bus.frame_valid = 1'b1;
        while (!bus.frame_ready && n < 3000) begin
            step();
            n++;
        end
        chk("send_ready", bus.frame_ready, 1);
        acc = cyc + 1;
        step();
        bus.frame_valid = 1'b0;
    endtask

    task automatic wait_rx(input int cnt, input int bound);
        int n = 0;
        while (rxq.size() < cnt && n < bound) begin
            step();
            n++;
        end
        chk("rx_arrive", rxq.size() >= cnt, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!bus.frame_ready && n < 3000) begin
            step();
            n++;
        end
    endtask

    vec_t         vecs[5];
    logic [N-1:0] expq[$];
    rx_t          r, r2;
    int           acc, acc2, rel, d0, n;
    logic [63:0]  rnd;
    logic [N-1:0] dv;

    initial begin
        vecs[0] = '{48'hFFFF_FFFF_FFFE, SENL, RLAT};
        vecs[1] = '{48'h0000_0000_0000, SENL, RLAT};
        vecs[2] = '{48'hFFFF_FFFF_FFFF, SENL, RLAT};
        vecs[3] = '{48'h8000_0000_0001, SENL, RLAT};
        vecs[4] = '{48'h1234_5678_9ABC, SENL, RLAT};

        rst_n = 1'b0;
        abort = 1'b0;
        bus.frame_valid = 1'b0;
        bus.frame_data = '0;
        repeat (3) step();
        chk("rst_sen", sen, 0);
        chk("rst_sclk", sclk, 0);
        chk("rst_sdata", sdata, 1);
        chk("rst_done", done, 0);
        chk("rst_ka", ka, 0);
        chk("rst_ready", bus.frame_ready, 1);

        // first keepalive after reset sends the all-closed word
        rst_n = 1'b1;
        rel = cyc;
        wait_rx(1, KP + 1500);
        if (rxq.size() > 0) begin
            r = rxq.pop_front();
            chk("boot_ka_time", r.rise - rel, KP);
            chk("boot_ka_word", r.word, {N{1'b1}});
            chk("boot_ka_flag", r.ka, 1);
        end
        chk("boot_no_partial", abq.size(), 0);
        wait_idle();
        chk("ka_clear", ka, 0);

        for (int i = 0; i < 5; i++) begin
            d0 = done_cnt;
            send(vecs[i].data, acc);
            wait_rx(1, 1500);
            if (rxq.size() > 0) begin
                r = rxq.pop_front();
                chk($sformatf("vec%0d_word", i), r.word, vecs[i].data);
                chk($sformatf("vec%0d_len", i), r.len, vecs[i].exp_len);
                chk($sformatf("vec%0d_rise", i), r.rise - acc, 0);
                chk($sformatf("vec%0d_ka", i), r.ka, 0);
            end
            wait_idle();
            chk($sformatf("vec%0d_lat", i), cyc - acc, vecs[i].exp_lat);
            chk($sformatf("vec%0d_done", i), done_cnt - d0, 1);
        end

        // valid held high across two words
        step();
        bus.frame_data = 48'h5555_5555_5555;
        bus.frame_valid = 1'b1;
        n = 0;
        while (!bus.frame_ready && n < 3000) begin step(); n++; end
        acc = cyc + 1;
        step();
        bus.frame_data = 48'hAAAA_AAAA_AAAA;
        n = 0;
        while (!bus.frame_ready && n < 3000) begin step(); n++; end
        acc2 = cyc + 1;
        step();
        bus.frame_valid = 1'b0;
        chk("b2b_accept", acc2 - acc, RLAT + 1);
        wait_rx(2, 1500);
        if (rxq.size() > 1) begin
            r = rxq.pop_front();
            r2 = rxq.pop_front();
            chk("b2b_word0", r.word, 48'h5555_5555_5555);
            chk("b2b_word1", r2.word, 48'hAAAA_AAAA_AAAA);
        end
        chk("b2b_gap", last_gap, GAPC + 1);
        wait_idle();

        // random words with random idle spacing
        for (int i = 0; i < 6; i++) begin
            rnd = {$urandom, $urandom};
            dv = rnd[N-1:0];
            expq.push_back(dv);
            repeat ($urandom_range(0, 20)) step();
            send(dv, acc);
        end
        wait_rx(6, 2500);
        while (expq.size() > 0 && rxq.size() > 0) begin
            dv = expq.pop_front();
            r = rxq.pop_front();
            chk("rand_word", r.word, dv);
            chk("rand_len", r.len, SENL);
        end
        wait_idle();

        // keepalive repeats the last accepted word
        send(48'h0000_0000_00FF, acc);
        wait_rx(1, 1500);
        if (rxq.size() > 0) r = rxq.pop_front();
        wait_rx(1, KP + 1500);
        if (rxq.size() > 0) begin
            r = rxq.pop_front();
            chk("ka1_time", r.rise - acc, KP);
            chk("ka1_word", r.word, 48'h0000_0000_00FF);
            chk("ka1_flag", r.ka, 1);
        end
        wait_rx(1, KP + 1500);
        if (rxq.size() > 0) begin
            r2 = rxq.pop_front();
            chk("ka2_time", r2.rise - r.rise, KP);
            chk("ka2_word", r2.word, 48'h0000_0000_00FF);
            chk("ka2_flag", r2.ka, 1);
        end
        wait_idle();

        // abort after the 20th rising edge
        d0 = done_cnt;
        send(48'h0123_4567_89AB, acc);
        n = 0;
        while (nbits != 20 && n < 1000) begin step(); n++; end
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_sen", sen, 0);
        chk("abort_sclk", sclk, 0);
        chk("abort_sdata", sdata, 1);
        step();
        chk("abort_partial", abq.size(), 1);
        if (abq.size() > 0) chk("abort_bits", abq.pop_front(), 20);
        wait_idle();
        chk("abort_no_done", done_cnt - d0, 0);
        wait_rx(1, KP + 1500);
        if (rxq.size() > 0) begin
            r = rxq.pop_front();
            chk("abort_ka_time", r.rise - acc, KP);
            chk("abort_ka_word", r.word, 48'h0123_4567_89AB);
            chk("abort_ka_flag", r.ka, 1);
        end
        wait_idle();

        // asynchronous reset while sclk is high
        send(48'hDEAD_BEEF_0042, acc);
        n = 0;
        while (!sclk && n < 1000) begin step(); n++; end
        #2 rst_n = 1'b0;
        #1;
        chk("arst_sen", sen, 0);
        chk("arst_sclk", sclk, 0);
        chk("arst_sdata", sdata, 1);
        step();
        rst_n = 1'b1;
        rel = cyc;
        chk("arst_ready", bus.frame_ready, 1);
        if (abq.size() > 0) chk("arst_short", abq.pop_front() < N, 1);
        wait_rx(1, KP + 1500);
        if (rxq.size() > 0) begin
            r = rxq.pop_front();
            chk("arst_ka_time", r.rise - rel, KP);
            chk("arst_ka_word", r.word, {N{1'b1}});
            chk("arst_ka_flag", r.ka, 1);
        end
        wait_idle();

        chk("sclk_while_sen_low", viol, 0);
        chk("sclk_spacing", spacing_err, 0);
        chk("done_vs_frames", done_cnt, n_full);
        chk("rx_leftover", rxq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
